// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU memory bus controller: command codes,
// MMIO addresses, FSM states and the address decoder.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10,
    MILL   = 2'b11
  } mem_cmd_e;

  localparam logic [8:0] LEDR_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR   = 9'h140;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    TGT_RAM,
    TGT_LEDR,
    TGT_SW,
    TGT_NONE
  } target_e;

  // RAM occupies the bottom of the map, so it wins over the MMIO constants
  function automatic target_e decode(input logic [8:0] addr, input int unsigned ram_words);
    if ({23'b0, addr} < ram_words) return TGT_RAM;
    if (addr == LEDR_ADDR)         return TGT_LEDR;
    if (addr == SW_ADDR)           return TGT_SW;
    return TGT_NONE;
  endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM: write and registered read share one address.
module ram_sp #(
  parameter int WORDS = 256,
  parameter int AW    = 8,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU-side memory bus controller: RAM plus LEDR/SW registers behind a
// three-state handshake FSM with one-cycle ready/error pulses.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int RAM_WORDS = 256,
  parameter int READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        mem_ready,
  output logic        bus_err,
  input  logic [7:0]  sw,
  output logic [7:0]  ledr
);

  state_e     state;
  logic [2:0] wait_cnt;
  mem_cmd_e   cmd_q;
  logic [8:0] addr_q;
  target_e    tgt_in;
  target_e    tgt_q;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [15:0] ram_q;

  assign tgt_in = decode(mem_addr, RAM_WORDS);
  assign tgt_q  = decode(addr_q, RAM_WORDS);
  assign ram_we = (state == IDLE) && (mem_cmd_e'(mem_cmd) == MWRITE) && (tgt_in == TGT_RAM);
  // Present the live address in IDLE so the RAM read starts on the accepting
  // edge; this is what lets READ_WAIT=0 return data in the DONE cycle.
  assign ram_addr = (state == IDLE) ? mem_addr[7:0] : addr_q[7:0];

  ram_sp #(.WORDS(RAM_WORDS), .AW(8), .DW(16)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (write_data),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      read_data <= 16'h0000;
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;
      ledr      <= 8'h00;
      wait_cnt  <= 3'd0;
      cmd_q     <= MNONE;
      addr_q    <= 9'h000;
    end else begin
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          cmd_q  <= mem_cmd_e'(mem_cmd);
          addr_q <= mem_addr;
          case (mem_cmd_e'(mem_cmd))
            MREAD: begin
              if (READ_WAIT == 0) begin
                state <= DONE;
              end else begin
                wait_cnt <= 3'(READ_WAIT);
                state    <= RD_WAIT;
              end
            end
            MWRITE: begin
              if (tgt_in == TGT_LEDR) ledr <= write_data[7:0];
              state <= DONE;
            end
            MILL:    bus_err <= 1'b1;
            default: ;
          endcase
        end
        RD_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) state <= DONE;
        end
        DONE: begin
          mem_ready <= 1'b1;
          state     <= IDLE;
          if (cmd_q == MREAD) begin
            case (tgt_q)
              TGT_RAM: read_data <= ram_q;
              TGT_SW:  read_data <= {8'h00, sw};
              default: begin
                read_data <= 16'h0000;
                bus_err   <= 1'b1;
              end
            endcase
          end else if (tgt_q != TGT_RAM && tgt_q != TGT_LEDR) begin
            bus_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed scoreboard bench for mem_bus_ctrl: one READ_WAIT=1 instance for the
// main map and error cases, one READ_WAIT=0 instance for back-to-back reads.
module tb_mem_bus_ctrl;
  import mem_bus_pkg::*;

  localparam int RW = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_ready;
  logic        bus_err;
  logic [7:0]  sw;
  logic [7:0]  ledr;

  logic [1:0]  cmd0;
  logic [8:0]  addr0;
  logic [15:0] wdata0;
  logic [15:0] rdata0;
  logic        ready0;
  logic        err0;
  logic [7:0]  sw0;
  logic [7:0]  ledr0;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [15:0] data;
    logic        err;
    logic        is_read;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_bus_ctrl #(.RAM_WORDS(256), .READ_WAIT(RW)) dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .read_data(read_data), .mem_ready(mem_ready),
    .bus_err(bus_err), .sw(sw), .ledr(ledr)
  );

  mem_bus_ctrl #(.RAM_WORDS(256), .READ_WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .mem_cmd(cmd0), .mem_addr(addr0),
    .write_data(wdata0), .read_data(rdata0), .mem_ready(ready0),
    .bus_err(err0), .sw(sw0), .ledr(ledr0)
  );

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one command at a negedge and push what the bus should answer
  task automatic applyStimulus(input logic [1:0] cmd, input logic [8:0] addr,
                               input logic [15:0] wd, input logic [15:0] exp_data,
                               input logic exp_err, input string tag);
    exp_t e;
    e.tag     = tag;
    e.data    = exp_data;
    e.err     = exp_err;
    e.is_read = (cmd == MREAD);
    e.lat     = e.is_read ? RW + 2 : 2;
    sb.push_back(e);
    @(negedge clk);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = wd;
  endtask

  // Wait (bounded) for the completion pulse and compare against the scoreboard
  task automatic checkOutput();
    exp_t e;
    logic seen;
    int   n;
    e    = sb.pop_front();
    seen = 1'b0;
    n    = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) mem_cmd = MNONE;
      if (mem_ready) begin
        seen = 1'b1;
        n    = i;
      end
    end
    checkEq({e.tag, " ready"}, 32'(seen), 32'd1);
    if (seen) begin
      checkEq({e.tag, " latency"}, n, e.lat);
      checkEq({e.tag, " bus_err"}, 32'(bus_err), 32'(e.err));
      if (e.is_read) checkEq({e.tag, " read_data"}, 32'(read_data), 32'(e.data));
      @(negedge clk);
      checkEq({e.tag, " ready width"}, 32'(mem_ready), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic       any_ready;
    logic       any_err;
    logic [3:0] pat;
    logic [15:0] got0;

    reset = 1'b1; mem_cmd = MNONE; mem_addr = '0; write_data = '0; sw = 8'h00;
    cmd0 = MNONE; addr0 = '0; wdata0 = '0; sw0 = 8'h00;
    repeat (3) @(negedge clk);
    checkEq("reset read_data", 32'(read_data), 32'h0);
    checkEq("reset mem_ready", 32'(mem_ready), 32'h0);
    checkEq("reset bus_err", 32'(bus_err), 32'h0);
    checkEq("reset ledr", 32'(ledr), 32'h0);
    checkEq("reset ready0", 32'(ready0), 32'h0);
    reset = 1'b0;

    applyStimulus(MWRITE, 9'h005, 16'hBEEF, 16'h0, 1'b0, "wr 005");   checkOutput();
    applyStimulus(MREAD,  9'h005, 16'h0,    16'hBEEF, 1'b0, "rd 005"); checkOutput();
    applyStimulus(MWRITE, 9'h0FF, 16'h1234, 16'h0, 1'b0, "wr 0FF");   checkOutput();
    applyStimulus(MREAD,  9'h0FF, 16'h0,    16'h1234, 1'b0, "rd 0FF"); checkOutput();
    applyStimulus(MWRITE, 9'h100, 16'h12A5, 16'h0, 1'b0, "wr ledr");  checkOutput();
    checkEq("ledr value", 32'(ledr), 32'hA5);
    sw = 8'h3C;
    applyStimulus(MREAD,  9'h140, 16'h0, 16'h003C, 1'b0, "rd sw");    checkOutput();
    applyStimulus(MREAD,  9'h100, 16'h0, 16'h0000, 1'b1, "rd ledr");  checkOutput();
    applyStimulus(MREAD,  9'h1FF, 16'h0, 16'h0000, 1'b1, "rd 1FF");   checkOutput();
    applyStimulus(MWRITE, 9'h1FF, 16'h5A5A, 16'h0, 1'b1, "wr 1FF");   checkOutput();
    checkEq("ledr after bad wr", 32'(ledr), 32'hA5);
    applyStimulus(MWRITE, 9'h140, 16'h7777, 16'h0, 1'b1, "wr sw");    checkOutput();
    checkEq("ledr after sw wr", 32'(ledr), 32'hA5);
    applyStimulus(MREAD,  9'h005, 16'h0, 16'hBEEF, 1'b0, "rd 005 again"); checkOutput();

    // Illegal command held for exactly one cycle
    @(negedge clk); mem_cmd = MILL;
    @(negedge clk); mem_cmd = MNONE;
    checkEq("illegal bus_err", 32'(bus_err), 32'd1);
    checkEq("illegal mem_ready", 32'(mem_ready), 32'd0);
    any_ready = 1'b0; any_err = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any_ready |= mem_ready;
      any_err   |= bus_err;
    end
    checkEq("illegal no ready", 32'(any_ready), 32'd0);
    checkEq("illegal single err", 32'(any_err), 32'd0);
    applyStimulus(MWRITE, 9'h010, 16'hAAAA, 16'h0, 1'b0, "wr after illegal"); checkOutput();

    // Reset while the read is waiting
    @(negedge clk); mem_cmd = MREAD; mem_addr = 9'h0FF;
    @(negedge clk); mem_cmd = MNONE; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checkEq("midrd read_data", 32'(read_data), 32'h0);
    checkEq("midrd ledr", 32'(ledr), 32'h0);
    any_ready = mem_ready;
    repeat (4) begin
      @(negedge clk);
      any_ready |= mem_ready;
    end
    checkEq("midrd no ready", 32'(any_ready), 32'd0);
    applyStimulus(MREAD, 9'h0FF, 16'h0, 16'h1234, 1'b0, "rd after reset"); checkOutput();

    // READ_WAIT=0 instance: seed word 0, then hold a read for four edges
    @(negedge clk); cmd0 = MWRITE; addr0 = 9'h000; wdata0 = 16'hC0DE;
    @(negedge clk); cmd0 = MNONE;
    checkEq("rw0 wr early", 32'(ready0), 32'd0);
    @(negedge clk);
    checkEq("rw0 wr ready", 32'(ready0), 32'd1);
    @(negedge clk); cmd0 = MREAD;
    pat = 4'b0; got0 = 16'h0; any_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat = {pat[2:0], ready0};
      any_err |= err0;
      if (ready0) got0 = rdata0;
    end
    cmd0 = MNONE;
    checkEq("rw0 pulse pattern", 32'(pat), 32'b0101);
    checkEq("rw0 read_data", 32'(got0), 32'hC0DE);
    checkEq("rw0 no err", 32'(any_err), 32'd0);
    any_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any_ready |= ready0;
    end
    checkEq("rw0 stops", 32'(any_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, meaning the number of 16-bit RAM words (max 256).
REQ-002 SHALL have parameter READ_WAIT, default 1, meaning extra wait cycles per RAM read (0..7).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit, the system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port mem_cmd, input, 2 bits, the CPU command: 00 NONE, 01 READ, 10 WRITE, 11 illegal.
REQ-007 SHALL have port mem_addr, input, 9 bits, the CPU word address.
REQ-008 SHALL have port write_data, input, 16 bits, the CPU store data.
REQ-009 SHALL have port read_data, output, 16 bits, registered load data returned to the CPU.
REQ-010 SHALL have port mem_ready, output, 1 bit, a one-cycle completion pulse.
REQ-011 SHALL have port bus_err, output, 1 bit, a one-cycle error pulse.
REQ-012 SHALL have port sw, input, 8 bits, the board switches.
REQ-013 SHALL have port ledr, output, 8 bits, the board LED register.

Function
REQ-014 SHALL decode the address map as follows:
- 0x000..RAM_WORDS-1: RAM.
- 0x100: LEDR, write-only.
- 0x140: SW, read-only.
- All other addresses: unmapped.
REQ-015 SHALL implement FSM states IDLE, RD_WAIT, DONE.
REQ-016 SHALL accept commands only in IDLE.
- Capture mem_cmd, mem_addr and write_data on the accepting edge.
- Ignore input changes in RD_WAIT and DONE.
REQ-017 SHALL, on IDLE+READ, load the wait counter with READ_WAIT and go to RD_WAIT; with READ_WAIT=0, go to DONE directly.
REQ-018 SHALL decrement the counter in RD_WAIT and go to DONE when the counter is 0.
REQ-019 SHALL handle IDLE+WRITE as follows:
- Perform the write on the accepting edge (RAM word or ledr<=write_data[7:0]).
- Go to DONE.
REQ-020 SHALL, in DONE, assert mem_ready for exactly one cycle and return to IDLE unconditionally.
REQ-021 SHALL give write latency as: mem_ready high in cycle N+1 for a command accepted at edge N.
REQ-022 SHALL give read latency as: mem_ready high in cycle N+1+READ_WAIT for a command accepted at edge N.
REQ-023 SHALL make read_data valid in the mem_ready cycle and hold it until the next read completes.
REQ-024 SHALL return SW reads as {8'h00, sw}, with sw sampled in the DONE-entry cycle.
REQ-025 SHALL handle unmapped and write-only-address reads as follows:
- read_data<=16'h0000.
- mem_ready and bus_err both pulse in the DONE cycle.
REQ-026 SHALL handle unmapped and read-only-address writes as follows:
- The write is dropped.
- mem_ready and bus_err both pulse in the DONE cycle.
REQ-027 SHALL treat mem_cmd=11 in IDLE as follows:
- Remain in IDLE.
- Pulse bus_err in the next cycle.
- No mem_ready.
REQ-028 SHALL re-accept a command still held at the next IDLE edge as a new transaction; the requester must drop or change mem_cmd on mem_ready.
REQ-029 SHALL limit throughput to 1 write per 2 cycles and 1 read per READ_WAIT+2 cycles.

Reset
REQ-030 SHALL, on reset, set state to IDLE, read_data=0, mem_ready=0, bus_err=0, ledr=0 and wait counter=0.
REQ-031 SHALL, on reset mid-transaction, abort without a mem_ready pulse; a write already performed at acceptance is not undone.
REQ-032 SHALL not initialise RAM contents on reset.

Structure
REQ-033 SHALL place in shared package mem_bus_pkg:
- The mem_cmd encodings (MNONE, MREAD, MWRITE).
- The LEDR/SW address constants.
- The FSM state enum.
REQ-034 SHALL instantiate one sub-module, ram_sp: a single-port synchronous RAM with synchronous write and registered read.

Verification
REQ-035 SHALL cover write then read: WRITE 0x005 data 16'hBEEF, then READ 0x005 (READ_WAIT=1) -> mem_ready 3 cycles after read accept, read_data=16'hBEEF.
REQ-036 SHALL cover MMIO: WRITE 0x100 data 16'h12A5 -> ledr=8'hA5; sw=8'h3C, READ 0x140 -> read_data=16'h003C, bus_err=0.
REQ-037 SHALL cover an unmapped access: READ 0x1FF -> read_data=0, mem_ready and bus_err pulse together; WRITE 0x1FF -> RAM and ledr unchanged, bus_err pulse.
REQ-038 SHALL cover the illegal command: mem_cmd=11 for 1 cycle -> bus_err one pulse, mem_ready stays 0, FSM stays IDLE.
REQ-039 SHALL cover reset mid-read: READ accepted, reset in RD_WAIT -> no mem_ready, read_data=0, next READ completes normally.
REQ-040 SHALL cover READ_WAIT=0 back-to-back: READ 0x000 held 4 cycles -> two mem_ready pulses, 2 cycles apart.
